id_stage: RTL and testbench

- Instruction-decode stage of the 5-stage RV32I pipeline. It sits between the IF/ID register and the ID/EX pipeline register.
- Contains the 32x32 register file, the main control decoder, immediate extension, and load-use hazard detection.
- Its outputs drive the ID/EX register's _ID inputs, plus the PC and IF/ID enables.

---
 rtl/id_stage_if.sv | 10 +
 rtl/id_stage.sv | 168 ++++++++++++++++
 tb/tb_id_stage.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/id_stage_if.sv
// Writeback bus into the decode stage: the register-file write port driven by WB.
// RegWrite_WB qualifies RD_WB/Result_WB in the same cycle; there is no backpressure (always accepted).
interface id_stage_if;
  logic        RegWrite_WB;
  logic [4:0]  RD_WB;
  logic [31:0] Result_WB;

  modport master (output RegWrite_WB, output RD_WB, output Result_WB);
  modport slave  (input  RegWrite_WB, input  RD_WB, input  Result_WB);
endinterface

// File: rtl/id_stage.sv
// RV32I decode stage: register file with WB bypass, control decode, immediates, load-use stall.
// Optional macro ID_PERF_CNT_EN adds stall_cnt/flush_cnt performance counters.
module id_stage #(
  parameter bit ZERO_ON_RESET = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  id_stage_if.slave   wb,
  input  logic [31:0] instr_ID,
  input  logic [31:0] PC_in,
  input  logic        MemToReg_EX,
  input  logic [4:0]  RD_EX,
  input  logic        flush_ID,
  output logic [31:0] PC_ID,
  output logic [31:0] RD1_ID,
  output logic [31:0] RD2_ID,
  output logic [31:0] ImmExt_ID,
  output logic [4:0]  RS1_ID,
  output logic [4:0]  RS2_ID,
  output logic [4:0]  RD_ID,
  output logic [2:0]  funct3_ID,
  output logic        funct7b5_ID,
  output logic        ALUSrc_ID,
  output logic [1:0]  ALUOp_ID,
  output logic        Branch_ID,
  output logic        RegWrite_ID,
  output logic        MemToReg_ID,
  output logic        MemWrite_ID,
  output logic        illegal_ID,
  output logic        stall_ID,
  output logic        enable_PC,
`ifdef ID_PERF_CNT_EN
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt,
`endif
  output logic        enable_IF_ID
);

  typedef enum logic [6:0] {
    OP_R     = 7'b0110011,
    OP_IALU  = 7'b0010011,
    OP_LOAD  = 7'b0000011,
    OP_STORE = 7'b0100011,
    OP_BR    = 7'b1100011
  } opcode_e;

  logic [31:0] regs_q [32];
  logic        wr_en;
  logic [4:0]  rs1, rs2;

  assign rs1   = instr_ID[19:15];
  assign rs2   = instr_ID[24:20];
  assign wr_en = wb.RegWrite_WB && (wb.RD_WB != 5'd0);

  generate
    if (ZERO_ON_RESET) begin : g_rf_rst
      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          for (int i = 0; i < 32; i++) regs_q[i] <= '0;
        end else if (wr_en) begin
          regs_q[wb.RD_WB] <= wb.Result_WB;
        end
      end
    end else begin : g_rf_norst
      always_ff @(posedge clock) begin
        if (wr_en) regs_q[wb.RD_WB] <= wb.Result_WB;
      end
    end
  endgenerate

  // Write-before-read: a same-cycle WB write to the read address is returned directly.
  always_comb begin
    RD1_ID = '0;
    RD2_ID = '0;
    if (rs1 != 5'd0) RD1_ID = (wr_en && wb.RD_WB == rs1) ? wb.Result_WB : regs_q[rs1];
    if (rs2 != 5'd0) RD2_ID = (wr_en && wb.RD_WB == rs2) ? wb.Result_WB : regs_q[rs2];
  end

  logic       dec_alusrc, dec_branch, dec_regwrite, dec_memtoreg, dec_memwrite, dec_illegal;
  logic [1:0] dec_aluop;
  logic       uses_rs1, uses_rs2;
  logic       bubble;

  always_comb begin
    dec_alusrc   = 1'b0;
    dec_aluop    = 2'b00;
    dec_branch   = 1'b0;
    dec_regwrite = 1'b0;
    dec_memtoreg = 1'b0;
    dec_memwrite = 1'b0;
    dec_illegal  = 1'b0;
    uses_rs1     = 1'b0;
    uses_rs2     = 1'b0;
    ImmExt_ID    = '0;
    case (instr_ID[6:0])
      OP_R: begin
        dec_aluop = 2'b10; dec_regwrite = 1'b1;
        uses_rs1 = 1'b1; uses_rs2 = 1'b1;
      end
      OP_IALU: begin
        dec_alusrc = 1'b1; dec_aluop = 2'b10; dec_regwrite = 1'b1;
        uses_rs1 = 1'b1;
        ImmExt_ID = {{20{instr_ID[31]}}, instr_ID[31:20]};
      end
      OP_LOAD: begin
        dec_alusrc = 1'b1; dec_regwrite = 1'b1; dec_memtoreg = 1'b1;
        uses_rs1 = 1'b1;
        ImmExt_ID = {{20{instr_ID[31]}}, instr_ID[31:20]};
      end
      OP_STORE: begin
        dec_alusrc = 1'b1; dec_memwrite = 1'b1;
        uses_rs1 = 1'b1; uses_rs2 = 1'b1;
        ImmExt_ID = {{20{instr_ID[31]}}, instr_ID[31:25], instr_ID[11:7]};
      end
      OP_BR: begin
        dec_aluop = 2'b01; dec_branch = 1'b1;
        uses_rs1 = 1'b1; uses_rs2 = 1'b1;
        ImmExt_ID = {{20{instr_ID[31]}}, instr_ID[7], instr_ID[30:25], instr_ID[11:8], 1'b0};
      end
      default: dec_illegal = 1'b1;
    endcase
  end

  // A squashed instruction never stalls; either condition turns the slot into a bubble.
  assign stall_ID = MemToReg_EX && (RD_EX != 5'd0) &&
                    ((uses_rs1 && RD_EX == rs1) || (uses_rs2 && RD_EX == rs2)) && !flush_ID;
  assign bubble   = stall_ID || flush_ID;

  assign ALUSrc_ID    = dec_alusrc   & ~bubble;
  assign ALUOp_ID     = dec_aluop    & {2{~bubble}};
  assign Branch_ID    = dec_branch   & ~bubble;
  assign RegWrite_ID  = dec_regwrite & ~bubble;
  assign MemToReg_ID  = dec_memtoreg & ~bubble;
  assign MemWrite_ID  = dec_memwrite & ~bubble;
  assign illegal_ID   = dec_illegal  & ~bubble;

  assign enable_PC    = ~stall_ID;
  assign enable_IF_ID = ~stall_ID;

  assign PC_ID       = PC_in;
  assign RS1_ID      = rs1;
  assign RS2_ID      = rs2;
  assign RD_ID       = instr_ID[11:7];
  assign funct3_ID   = instr_ID[14:12];
  assign funct7b5_ID = instr_ID[30];

`ifdef ID_PERF_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  assign stall_cnt_d = stall_cnt_q + {31'd0, stall_ID};
  assign flush_cnt_d = flush_cnt_q + {31'd0, flush_ID};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_id_stage.sv
// Directed bench for id_stage: register file, bypass, decode, immediates, load-use, flush, reset.
module tb_id_stage;
  logic        clock;
  logic        reset;
  logic [31:0] instr_ID, PC_in;
  logic        MemToReg_EX, flush_ID;
  logic [4:0]  RD_EX;
  logic [31:0] PC_ID, RD1_ID, RD2_ID, ImmExt_ID;
  logic [4:0]  RS1_ID, RS2_ID, RD_ID;
  logic [2:0]  funct3_ID;
  logic        funct7b5_ID, ALUSrc_ID, Branch_ID, RegWrite_ID, MemToReg_ID, MemWrite_ID;
  logic [1:0]  ALUOp_ID;
  logic        illegal_ID, stall_ID, enable_PC, enable_IF_ID;
`ifdef ID_PERF_CNT_EN
  logic [31:0] stall_cnt, flush_cnt;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  id_stage_if wb ();

  id_stage #(.ZERO_ON_RESET(1'b1)) dut (
    .clock(clock), .reset(reset), .wb(wb.slave),
    .instr_ID(instr_ID), .PC_in(PC_in),
    .MemToReg_EX(MemToReg_EX), .RD_EX(RD_EX), .flush_ID(flush_ID),
    .PC_ID(PC_ID), .RD1_ID(RD1_ID), .RD2_ID(RD2_ID), .ImmExt_ID(ImmExt_ID),
    .RS1_ID(RS1_ID), .RS2_ID(RS2_ID), .RD_ID(RD_ID),
    .funct3_ID(funct3_ID), .funct7b5_ID(funct7b5_ID),
    .ALUSrc_ID(ALUSrc_ID), .ALUOp_ID(ALUOp_ID), .Branch_ID(Branch_ID),
    .RegWrite_ID(RegWrite_ID), .MemToReg_ID(MemToReg_ID), .MemWrite_ID(MemWrite_ID),
    .illegal_ID(illegal_ID), .stall_ID(stall_ID), .enable_PC(enable_PC),
`ifdef ID_PERF_CNT_EN
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt),
`endif
    .enable_IF_ID(enable_IF_ID)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  // driver tasks
  task automatic wb_write(input logic [4:0] rd, input logic [31:0] d);
    @(negedge clock);
    wb.RegWrite_WB = 1'b1; wb.RD_WB = rd; wb.Result_WB = d;
    @(posedge clock); #1;
    wb.RegWrite_WB = 1'b0; wb.RD_WB = '0; wb.Result_WB = '0;
  endtask

  task automatic decode(input logic [31:0] ins);
    @(negedge clock);
    instr_ID = ins;
    #1;
  endtask

  task automatic set_ex(input logic m2r, input logic [4:0] rd, input logic fl);
    @(negedge clock);
    MemToReg_EX = m2r; RD_EX = rd; flush_ID = fl;
  endtask

  initial begin
    reset = 1'b1;
    instr_ID = '0; PC_in = 32'h0000_1000;
    MemToReg_EX = 1'b0; RD_EX = '0; flush_ID = 1'b0;
    wb.RegWrite_WB = 1'b0; wb.RD_WB = '0; wb.Result_WB = '0;
    repeat (2) @(posedge clock);
    #1;
    check("rst_rd1", RD1_ID, 32'h0);
    check("rst_stall", {31'd0, stall_ID}, 32'd0);
    check("rst_en_pc", {31'd0, enable_PC}, 32'd1);
    check("rst_en_ifid", {31'd0, enable_IF_ID}, 32'd1);
    check("rst_regwrite", {31'd0, RegWrite_ID}, 32'd0);
    check("rst_aluop", {30'd0, ALUOp_ID}, 32'd0);
    check("nop_illegal", {31'd0, illegal_ID}, 32'd1);
    check("pc_pass", PC_ID, 32'h0000_1000);
    @(negedge clock); reset = 1'b0;

    // add x1,x5,x0 after writing x5
    wb_write(5'd5, 32'hDEAD_BEEF);
    decode(32'h0002_80B3);
    check("wr_rd1", RD1_ID, 32'hDEAD_BEEF);
    check("wr_rd2", RD2_ID, 32'h0);
    check("add_aluop", {30'd0, ALUOp_ID}, 32'd2);
    check("add_regwrite", {31'd0, RegWrite_ID}, 32'd1);
    check("add_alusrc", {31'd0, ALUSrc_ID}, 32'd0);
    check("add_illegal", {31'd0, illegal_ID}, 32'd0);
    check("add_rs1", {27'd0, RS1_ID}, 32'd5);
    check("add_rd", {27'd0, RD_ID}, 32'd1);

    // x0 is never written nor bypassed
    @(negedge clock);
    instr_ID = 32'h0000_00B3;
    wb.RegWrite_WB = 1'b1; wb.RD_WB = 5'd0; wb.Result_WB = 32'h1234;
    #1;
    check("x0_nobypass", RD1_ID, 32'h0);
    @(posedge clock); #1;
    wb.RegWrite_WB = 1'b0; wb.RD_WB = '0; wb.Result_WB = '0;
    decode(32'h0000_00B3);
    check("x0_read", RD1_ID, 32'h0);

    // same-cycle bypass on both ports: add x8,x7,x7
    @(negedge clock);
    instr_ID = 32'h0073_8433;
    wb.RegWrite_WB = 1'b1; wb.RD_WB = 5'd7; wb.Result_WB = 32'hA5A5_A5A5;
    #1;
    check("byp_rd1", RD1_ID, 32'hA5A5_A5A5);
    check("byp_rd2", RD2_ID, 32'hA5A5_A5A5);
    @(posedge clock); #1;
    wb.RegWrite_WB = 1'b0; wb.RD_WB = '0; wb.Result_WB = '0;
    #1;
    check("byp_stored", RD2_ID, 32'hA5A5_A5A5);

    // independent bypass: add x8,x7,x5 with WB to x7 only
    @(negedge clock);
    instr_ID = 32'h0053_8433;
    wb.RegWrite_WB = 1'b1; wb.RD_WB = 5'd7; wb.Result_WB = 32'h1111_2222;
    #1;
    check("byp1_rd1", RD1_ID, 32'h1111_2222);
    check("byp1_rd2", RD2_ID, 32'hDEAD_BEEF);
    @(posedge clock); #1;
    wb.RegWrite_WB = 1'b0; wb.RD_WB = '0; wb.Result_WB = '0;

    // load-use: add x4,x3,x2 with load to x3 in EX
    set_ex(1'b1, 5'd3, 1'b0);
    decode(32'h0021_8233);
    check("lu_stall", {31'd0, stall_ID}, 32'd1);
    check("lu_en_pc", {31'd0, enable_PC}, 32'd0);
    check("lu_en_ifid", {31'd0, enable_IF_ID}, 32'd0);
    check("lu_regwrite", {31'd0, RegWrite_ID}, 32'd0);
    check("lu_aluop", {30'd0, ALUOp_ID}, 32'd0);
    check("lu_rs2_pass", {27'd0, RS2_ID}, 32'd2);

    // stalled-on register still bypassed from WB
    @(negedge clock);
    wb.RegWrite_WB = 1'b1; wb.RD_WB = 5'd3; wb.Result_WB = 32'hCAFE_0003;
    #1;
    check("lu_byp_rd1", RD1_ID, 32'hCAFE_0003);
    check("lu_byp_stall", {31'd0, stall_ID}, 32'd1);
    @(posedge clock); #1;
    wb.RegWrite_WB = 1'b0; wb.RD_WB = '0; wb.Result_WB = '0;

    // match on rs2: add x4,x2,x3
    decode(32'h0031_0233);
    check("lu_rs2_stall", {31'd0, stall_ID}, 32'd1);

    // I-ALU whose rs2 field is 3: addi x4,x2,3
    decode(32'h0031_0213);
    check("ialu_nostall", {31'd0, stall_ID}, 32'd0);
    check("ialu_regwrite", {31'd0, RegWrite_ID}, 32'd1);
    check("ialu_imm", ImmExt_ID, 32'd3);

    // RD_EX = 0 never stalls
    set_ex(1'b1, 5'd0, 1'b0);
    decode(32'h0000_8233);
    check("rdex0_nostall", {31'd0, stall_ID}, 32'd0);

    // flush beats stall
    set_ex(1'b1, 5'd3, 1'b1);
    decode(32'h0021_8233);
    check("fl_stall", {31'd0, stall_ID}, 32'd0);
    check("fl_en_pc", {31'd0, enable_PC}, 32'd1);
    check("fl_en_ifid", {31'd0, enable_IF_ID}, 32'd1);
    check("fl_ctrl", {26'd0, ALUSrc_ID, ALUOp_ID, Branch_ID, RegWrite_ID, MemToReg_ID, MemWrite_ID}, 32'd0);
    decode(32'h0000_10B7);
    check("fl_illegal", {31'd0, illegal_ID}, 32'd0);
    set_ex(1'b0, 5'd0, 1'b0);

    // immediates; beq with instr[7]=1 gives imm[11]=1
    decode(32'hFE00_0EE3);
    check("beq_imm", ImmExt_ID, 32'hFFFF_FFFC);
    check("beq_branch", {31'd0, Branch_ID}, 32'd1);
    check("beq_aluop", {30'd0, ALUOp_ID}, 32'd1);
    decode(32'hFE00_0E63);
    check("beq_imm_b11", ImmExt_ID, 32'hFFFF_F7FC);
    // sw x2,-4(x1)
    decode(32'hFE20_AE23);
    check("sw_imm", ImmExt_ID, 32'hFFFF_FFFC);
    check("sw_memwrite", {31'd0, MemWrite_ID}, 32'd1);
    check("sw_alusrc", {31'd0, ALUSrc_ID}, 32'd1);
    check("sw_regwrite", {31'd0, RegWrite_ID}, 32'd0);
    // lw x6,8(x1)
    decode(32'h0080_A303);
    check("lw_imm", ImmExt_ID, 32'd8);
    check("lw_memtoreg", {31'd0, MemToReg_ID}, 32'd1);
    check("lw_funct3", {29'd0, funct3_ID}, 32'd2);
    // addi x1,x0,-1
    decode(32'hFFF0_0093);
    check("addi_imm", ImmExt_ID, 32'hFFFF_FFFF);
    check("addi_f7b5", {31'd0, funct7b5_ID}, 32'd1);
    // lui is unsupported here
    decode(32'h0000_10B7);
    check("lui_illegal", {31'd0, illegal_ID}, 32'd1);
    check("lui_ctrl", {26'd0, ALUSrc_ID, ALUOp_ID, Branch_ID, RegWrite_ID, MemToReg_ID, MemWrite_ID}, 32'd0);
    check("lui_imm", ImmExt_ID, 32'd0);

    // asynchronous reset mid-run clears the file
    decode(32'h0053_8433);
    check("pre_rst_rd1", RD1_ID, 32'h1111_2222);
    @(negedge clock); #2;
    reset = 1'b1;
    #1;
    check("midrst_rd1", RD1_ID, 32'h0);
    check("midrst_rd2", RD2_ID, 32'h0);
    @(negedge clock); reset = 1'b0;

`ifdef ID_PERF_CNT_EN
    set_ex(1'b1, 5'd3, 1'b0);
    instr_ID = 32'h0021_8233;
    repeat (3) @(posedge clock);
    set_ex(1'b0, 5'd0, 1'b1);
    repeat (2) @(posedge clock);
    set_ex(1'b0, 5'd0, 1'b0);
    #1;
    check("stall_cnt", stall_cnt, 32'd3);
    check("flush_cnt", flush_cnt, 32'd2);
    reset = 1'b1;
    #1;
    check("stall_cnt_rst", stall_cnt, 32'd0);
    check("flush_cnt_rst", flush_cnt, 32'd0);
    @(negedge clock); reset = 1'b0;
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
